// File: rtl/parameters.sv
`default_nettype none
// ============================================================================
// parameters.sv - Shared bus widths for the Wishbone master.
// Revision: 1.0
// ============================================================================
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`default_nettype wire

// File: rtl/wb_master.sv
`default_nettype none
// ============================================================================
// wb_master - Wishbone classic burst master (1..16 beats, incrementing addr).
// Optional stall timeout: define WB_MASTER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module wb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_we_i,
  input  logic [`ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [3:0]             cmd_len_i,
  input  logic [`DATA_WIDTH-1:0] wdata_i,
  input  logic                   wdata_valid_i,
  output logic                   wdata_ready_o,
  output logic [`DATA_WIDTH-1:0] rdata_o,
  output logic                   rdata_valid_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [`ADDR_WIDTH-1:0] adr_o,
  output logic [`DATA_WIDTH-1:0] dat_o,
  output logic                   we_o,
  output logic                   cyc_o,
  output logic                   stb_o,
  input  logic [`DATA_WIDTH-1:0] dat_i,
  input  logic                   ack_i
);

  localparam int         c_aw     = `ADDR_WIDTH;
  localparam logic [0:0] c_idle   = 1'b0;
  localparam logic [0:0] c_active = 1'b1;

  logic [0:0] r_state;
  logic [3:0] r_beats;

  logic w_cmd_acc;
  logic w_wbeat_acc;
  logic w_beat_done;
  logic w_last;
  logic w_timeout;

  // The done cycle is held off from accepting so bursts never abut.
  assign cmd_ready_o   = (r_state == c_idle) & ~done_o;
  assign wdata_ready_o = (r_state == c_active) & we_o & ~stb_o;

  assign w_cmd_acc   = cmd_valid_i & cmd_ready_o;
  assign w_wbeat_acc = wdata_valid_i & wdata_ready_o;
  assign w_beat_done = stb_o & ack_i;
  assign w_last      = (r_beats == 4'd0);

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int                    c_stall_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_stall_w-1:0]  c_stall_last = c_stall_w'(TIMEOUT_CYCLES - 1);

  logic [c_stall_w-1:0] r_stall;

  // Restart counting whenever a strobe is raised or a beat completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall <= '0;
    end else if (w_cmd_acc | w_wbeat_acc | w_beat_done) begin
      r_stall <= '0;
    end else if (stb_o) begin
      r_stall <= r_stall + c_stall_w'(1);
    end
  end

  assign w_timeout = stb_o & ~ack_i & (r_stall == c_stall_last);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else begin
      err_o <= (r_state == c_active) & w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= c_idle;
      r_beats       <= 4'd0;
      cyc_o         <= 1'b0;
      stb_o         <= 1'b0;
      we_o          <= 1'b0;
      adr_o         <= '0;
      dat_o         <= '0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      rdata_valid_o <= 1'b0;
      done_o        <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_cmd_acc) begin
            r_state <= c_active;
            cyc_o   <= 1'b1;
            stb_o   <= ~cmd_we_i;
            we_o    <= cmd_we_i;
            adr_o   <= cmd_adr_i;
            r_beats <= cmd_len_i;
          end
        end
        c_active: begin
          if (w_beat_done) begin
            if (!we_o) begin
              rdata_o       <= dat_i;
              rdata_valid_o <= 1'b1;
            end
            if (w_last) begin
              r_state <= c_idle;
              cyc_o   <= 1'b0;
              stb_o   <= 1'b0;
              done_o  <= 1'b1;
            end else begin
              adr_o   <= adr_o + c_aw'(1);
              r_beats <= r_beats - 4'd1;
              // Writes wait for the next data beat; reads keep strobing.
              if (we_o) begin
                stb_o <= 1'b0;
              end
            end
          end else if (w_timeout) begin
            r_state <= c_idle;
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            done_o  <= 1'b1;
          end else if (w_wbeat_acc) begin
            dat_o <= wdata_i;
            stb_o <= 1'b1;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_master.sv
`default_nettype none
// ============================================================================
// tb_wb_master - Directed bench with a burst-level reference model.
// Revision: 1.0
// ============================================================================
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_wb_master;

  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [3:0]    cmd_len = '0;
  logic [DW-1:0] wdata = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          done;
  logic          err;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_o;
  logic          we;
  logic          cyc;
  logic          stb;
  logic [DW-1:0] dat_i = '0;
  logic          ack_i = 1'b0;

  always #5 clk = ~clk;

  wb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len),
    .wdata_i(wdata), .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
    .rdata_o(rdata), .rdata_valid_o(rdata_valid), .done_o(done), .err_o(err),
    .adr_o(adr), .dat_o(dat_o), .we_o(we), .cyc_o(cyc), .stb_o(stb),
    .dat_i(dat_i), .ack_i(ack_i)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_cyc = 0, n_rv = 0, n_done = 0, n_errp = 0;
  logic [AW-1:0] ack_adr[$];
  logic [DW-1:0] ack_dat[$];
  logic [DW-1:0] rv_dat[$];
  bit sim_end = 1'b0;

  // Reference model: one burst at a time, tracked as address / beats left.
  bit            m_valid = 1'b0;
  bit            m_act = 1'b0, m_we = 1'b0, m_pend = 1'b0;
  bit            m_done = 1'b0, m_errf = 1'b0, m_rv = 1'b0;
  logic [AW-1:0] m_adr = '0;
  logic [DW-1:0] m_dat = '0, m_rdata = '0;
  int            m_left = 0;
`ifdef WB_MASTER_TIMEOUT_EN
  int            m_stall = 0;
`endif
  bit            e_stb, e_rdy;

  int s_cyc, s_rv, s_done, s_errp, s_qa, s_qr, waited;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit w, input logic [AW-1:0] a, input logic [3:0] len,
                          output int nwait);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_len = len; nwait = 0;
    while (!cmd_ready && nwait < 50) begin
      tick();
      nwait++;
    end
    if (!cmd_ready) chk("cmd_accept_bound", {63'd0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic put_beat(input logic [DW-1:0] d);
    int n = 0;
    wdata_valid = 1'b1; wdata = d;
    while (!wdata_ready && n < 50) begin
      tick();
      n++;
    end
    if (!wdata_ready) chk("wdata_accept_bound", {63'd0, wdata_ready}, 64'd1);
    tick();
    wdata_valid = 1'b0;
  endtask

  task automatic ack_beat(input logic [DW-1:0] d);
    ack_i = 1'b1; dat_i = d;
    tick();
    ack_i = 1'b0;
  endtask

  task automatic snap();
    s_cyc = n_cyc; s_rv = n_rv; s_done = n_done; s_errp = n_errp;
    s_qa = ack_adr.size(); s_qr = rv_dat.size();
  endtask

  initial begin
    fork
      begin : compare
        while (!sim_end) begin
          @(negedge clk);
          e_stb = m_act && (!m_we || m_pend);
          e_rdy = !m_act && !m_done;
          if (m_valid) begin
            chk("cyc_o", {63'd0, cyc}, {63'd0, m_act});
            chk("stb_o", {63'd0, stb}, {63'd0, e_stb});
            if (m_act) begin
              chk("adr_o", 64'(adr), 64'(m_adr));
              chk("we_o", {63'd0, we}, {63'd0, m_we});
            end
            if (m_act && m_we && m_pend) chk("dat_o", 64'(dat_o), 64'(m_dat));
            chk("rdata_valid_o", {63'd0, rdata_valid}, {63'd0, m_rv});
            if (m_rv) chk("rdata_o", 64'(rdata), 64'(m_rdata));
            chk("done_o", {63'd0, done}, {63'd0, m_done});
            chk("err_o", {63'd0, err}, {63'd0, m_done && m_errf});
            chk("cmd_ready_o", {63'd0, cmd_ready}, {63'd0, e_rdy});
            chk("wdata_ready_o", {63'd0, wdata_ready}, {63'd0, m_act && m_we && !m_pend});
          end
          if (cyc === 1'b1) n_cyc++;
          if (rdata_valid === 1'b1) begin n_rv++; rv_dat.push_back(rdata); end
          if (done === 1'b1) n_done++;
          if (done === 1'b1 && err === 1'b1) n_errp++;
          if (cyc === 1'b1 && stb === 1'b1 && ack_i) begin
            ack_adr.push_back(adr);
            ack_dat.push_back(dat_o);
          end
          if (rst_i) begin
            m_valid = 1'b1; m_act = 1'b0; m_pend = 1'b0;
            m_done = 1'b0; m_errf = 1'b0; m_rv = 1'b0;
          end else begin
            m_done = 1'b0; m_errf = 1'b0; m_rv = 1'b0;
            if (!m_act) begin
              if (cmd_valid && e_rdy) begin
                m_act = 1'b1; m_we = cmd_we; m_adr = cmd_adr; m_left = int'(cmd_len);
                m_pend = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
                m_stall = 0;
`endif
              end
            end else if (e_stb && ack_i) begin
              if (!m_we) begin m_rv = 1'b1; m_rdata = dat_i; end
`ifdef WB_MASTER_TIMEOUT_EN
              m_stall = 0;
`endif
              m_pend = 1'b0;
              if (m_left == 0) begin
                m_act = 1'b0; m_done = 1'b1;
              end else begin
                m_adr = m_adr + AW'(1);
                m_left--;
              end
            end else if (e_stb) begin
`ifdef WB_MASTER_TIMEOUT_EN
              m_stall++;
              if (m_stall == TO) begin
                m_act = 1'b0; m_pend = 1'b0; m_done = 1'b1; m_errf = 1'b1;
              end
`endif
            end else if (m_we && wdata_valid) begin
              m_pend = 1'b1; m_dat = wdata;
`ifdef WB_MASTER_TIMEOUT_EN
              m_stall = 0;
`endif
            end
          end
        end
      end
      begin : stim
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        chk("reset_cyc", {63'd0, cyc}, 64'd0);
        chk("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // Single read, slave acks on the second strobe cycle.
        snap();
        send_cmd(1'b0, AW'('h10), 4'd0, waited);
        tick();
        ack_beat(DW'('hA5));
        tick(); tick();
        chk("rd1_cyc_cycles", 64'(n_cyc - s_cyc), 64'd2);
        chk("rd1_rv_count", 64'(n_rv - s_rv), 64'd1);
        chk("rd1_rdata", 64'(rv_dat[s_qr]), 64'hA5);
        chk("rd1_ack_adr", 64'(ack_adr[s_qa]), 64'h10);
        chk("rd1_done", 64'(n_done - s_done), 64'd1);
        chk("rd1_err", 64'(n_errp - s_errp), 64'd0);

        // Four-beat write with a three-cycle gap before beat 3.
        snap();
        send_cmd(1'b1, AW'('h20), 4'd3, waited);
        put_beat(DW'(1)); ack_beat('0);
        put_beat(DW'(2)); ack_beat('0);
        tick();
        ack_i = 1'b1;
        chk("gap_stb", {63'd0, stb}, 64'd0);
        tick();
        ack_i = 1'b0;
        chk("gap_adr", 64'(adr), 64'h22);
        chk("gap_cyc", {63'd0, cyc}, 64'd1);
        tick();
        put_beat(DW'(3)); ack_beat('0);
        put_beat(DW'(4)); ack_beat('0);
        tick(); tick();
        chk("wr_beats", 64'(ack_adr.size() - s_qa), 64'd4);
        for (int i = 0; i < 4; i++) begin
          chk("wr_ack_adr", 64'(ack_adr[s_qa + i]), 64'('h20 + i));
          chk("wr_ack_dat", 64'(ack_dat[s_qa + i]), 64'(i + 1));
        end
        chk("wr_cyc_cycles", 64'(n_cyc - s_cyc), 64'd11);
        chk("wr_done", 64'(n_done - s_done), 64'd1);
        chk("wr_rv_count", 64'(n_rv - s_rv), 64'd0);

        // Ack while idle is ignored.
        snap();
        ack_i = 1'b1;
        tick(); tick();
        ack_i = 1'b0;
        tick();
        chk("idle_ack_adr", 64'(adr), 64'h23);
        chk("idle_ack_beats", 64'(ack_adr.size() - s_qa), 64'd0);
        chk("idle_ack_done", 64'(n_done - s_done), 64'd0);

        // Two-beat read wrapping past the top of the address space.
        snap();
        send_cmd(1'b0, '1, 4'd1, waited);
        ack_beat(DW'('h1111_1111));
        ack_beat(DW'('h2222_2222));
        tick(); tick();
        chk("wrap_adr0", 64'(ack_adr[s_qa]), 64'(AW'('1)));
        chk("wrap_adr1", 64'(ack_adr[s_qa + 1]), 64'd0);
        chk("wrap_rv_count", 64'(n_rv - s_rv), 64'd2);
        chk("wrap_rdata0", 64'(rv_dat[s_qr]), 64'h1111_1111);
        chk("wrap_rdata1", 64'(rv_dat[s_qr + 1]), 64'h2222_2222);
        chk("wrap_done", 64'(n_done - s_done), 64'd1);

        // Reset during beat 2 of a four-beat read.
        snap();
        send_cmd(1'b0, AW'('h40), 4'd3, waited);
        ack_beat(DW'('hC0));
        chk("rst_mid_adr", 64'(adr), 64'h41);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_cyc", {63'd0, cyc}, 64'd0);
        chk("rst_stb", {63'd0, stb}, 64'd0);
        chk("rst_we", {63'd0, we}, 64'd0);
        chk("rst_adr", 64'(adr), 64'd0);
        chk("rst_dat", 64'(dat_o), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_rv", {63'd0, rdata_valid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_ready", {63'd0, cmd_ready}, 64'd1);
        send_cmd(1'b0, AW'('h50), 4'd0, waited);
        chk("rst_accept_wait", 64'(waited), 64'd0);
        chk("rst_no_done", 64'(n_done - s_done), 64'd0);
        ack_beat(DW'('h5A));
        tick(); tick();
        chk("rst_new_done", 64'(n_done - s_done), 64'd1);
        chk("rst_new_rdata", 64'(rv_dat[rv_dat.size() - 1]), 64'h5A);

        // Slave that never acks.
        snap();
        send_cmd(1'b0, AW'('h60), 4'd0, waited);
`ifdef WB_MASTER_TIMEOUT_EN
        waited = 0;
        while (!done && waited < 40) begin
          tick();
          waited++;
        end
        chk("to_done", {63'd0, done}, 64'd1);
        chk("to_err", {63'd0, err}, 64'd1);
        chk("to_cyc_cycles", 64'(n_cyc - s_cyc), 64'(TO));
        tick(); tick();
        chk("to_rv_count", 64'(n_rv - s_rv), 64'd0);
`else
        repeat (100) tick();
        chk("hang_cyc", {63'd0, cyc}, 64'd1);
        chk("hang_cyc_cycles", 64'(n_cyc - s_cyc), 64'd100);
        ack_beat(DW'('h77));
        tick(); tick();
        chk("hang_done", 64'(n_done - s_done), 64'd1);
`endif

        // Back-to-back request: the done cycle must not accept.
        snap();
        send_cmd(1'b0, AW'('h70), 4'd0, waited);
        ack_beat(DW'('h70));
        send_cmd(1'b1, AW'('h80), 4'd0, waited);
        chk("b2b_wait", 64'(waited), 64'd1);
        put_beat(DW'('h99));
        ack_beat('0);
        tick(); tick();
        chk("b2b_wr_adr", 64'(ack_adr[ack_adr.size() - 1]), 64'h80);
        chk("b2b_wr_dat", 64'(ack_dat[ack_dat.size() - 1]), 64'h99);
        chk("b2b_done", 64'(n_done - s_done), 64'd2);

        sim_end = 1'b1;
      end
    join
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_master.md
WB_MASTER -- requirements
Module: wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of stalled strobe cycles before abort (used only with WB_MASTER_TIMEOUT_EN).
REQ-002 SHALL take bus widths from `ADDR_WIDTH and `DATA_WIDTH in parameters.sv.
REQ-003 SHALL have ports:
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when both valid and ready are high.
- cmd_we_i  in  1  1 = write burst, 0 = read burst.
- cmd_adr_i  in  `ADDR_WIDTH  start address.
- cmd_len_i  in  4  beats minus 1 (1..16 beats).
- wdata_i  in  `DATA_WIDTH  write beat data.
- wdata_valid_i  in  1  write beat available.
- wdata_ready_o  out  1  write beat accepted when both valid and ready are high.
- rdata_o  out  `DATA_WIDTH  read beat data.
- rdata_valid_o  out  1  one-cycle pulse per read beat; no backpressure.
- done_o  out  1  one-cycle pulse at burst end.
- err_o  out  1  qualified by done_o; 1 = timeout abort.
- adr_o, dat_o, we_o, cyc_o, stb_o  out  Wishbone classic master outputs (`ADDR_WIDTH, `DATA_WIDTH, 1, 1, 1).
- dat_i, ack_i  in  Wishbone slave returns (`DATA_WIDTH, 1).

Function
REQ-004 SHALL implement states IDLE and ACTIVE; all bus outputs SHALL be registered.
REQ-005 cmd_ready_o SHALL be 1 only in IDLE.
REQ-006 On command acceptance: ACTIVE next cycle, cyc_o=1, adr_o=cmd_adr_i, we_o=cmd_we_i, beat counter=cmd_len_i.
REQ-007 Read burst: stb_o SHALL rise with cyc_o and stay high until the last ack.
REQ-008 Write burst: wdata_ready_o SHALL be 1 in ACTIVE with we_o=1 and stb_o=0. An accepted beat SHALL load dat_o and set stb_o=1 on the next cycle.
REQ-009 A beat completes at an edge where stb_o=1 and ack_i=1. ack_i while stb_o=0 SHALL be ignored.
REQ-010 On a non-final beat completion: adr_o SHALL increment by 1, with modulo 2^`ADDR_WIDTH wrap. The beat counter SHALL decrement. For writes, stb_o SHALL drop.
REQ-011 On a read beat completion: dat_i SHALL be captured into rdata_o, and rdata_valid_o SHALL pulse in the following cycle.
REQ-012 On the final beat completion (counter 0): next cycle cyc_o=0, stb_o=0, state IDLE, done_o=1, err_o=0.
REQ-013 A new command SHALL be accepted no earlier than the cycle after done_o. There SHALL be a minimum of one idle cycle with cyc_o=0 between bursts.
REQ-014 cyc_o SHALL remain high across write-data gaps (stb_o=0) within a burst.
REQ-015 Write-beat acceptance and beat completion SHALL never occur in the same cycle, since wdata_ready_o requires stb_o=0.

Reset
REQ-016 When rst_i is sampled high, at that edge: state=IDLE, cyc_o=0, stb_o=0, we_o=0, adr_o=0, dat_o=0, rdata_o=0, rdata_valid_o=0, done_o=0, err_o=0, counters=0.
REQ-017 Reset mid-burst SHALL abort the burst without asserting done_o. cmd_ready_o SHALL be 1 on the first cycle after rst_i deasserts.

Configuration
REQ-018 With WB_MASTER_TIMEOUT_EN defined, a stall counter SHALL count cycles with stb_o=1 and ack_i=0. The counter SHALL clear on each ack and on each stb_o rise.
REQ-019 With WB_MASTER_TIMEOUT_EN defined, the stall count reaching TIMEOUT_CYCLES SHALL force next cycle cyc_o=0, stb_o=0, IDLE, done_o=1, err_o=1. No further rdata_valid_o SHALL be produced for that burst.
REQ-020 Without WB_MASTER_TIMEOUT_EN, the master SHALL wait indefinitely for ack_i, err_o SHALL be constant 0, and no stall counter logic SHALL exist.

Verification
REQ-021 Single read: cmd adr=0x10, len=0; slave acks on the 2nd stb cycle with dat_i=0xA5 -> one rdata_valid_o with 0xA5; done_o=1, err_o=0; cyc_o high for exactly 2 cycles.
REQ-022 Write burst len=3 with data 1,2,3,4 and a 3-cycle gap before beat 3 -> adr_o sequence 0x20..0x23, dat_o matches per ack, stb_o low during the gap, cyc_o continuously high.
REQ-023 Read burst at adr=all-ones, len=1 -> second beat adr_o=0 (wrap); two rdata_valid_o pulses.
REQ-024 ack_i pulsed while in IDLE and while stb_o=0 in a write gap -> no beat counted; adr_o unchanged.
REQ-025 rst_i asserted during beat 2 of a 4-beat read -> all outputs 0 at the next edge; no done_o; a new command is accepted right after reset.
REQ-026 With WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks -> abort after 16 stall cycles with done_o=1, err_o=1. Without the macro -> cyc_o stays high for 100 cycles.
